stream_demux_1to2: RTL and testbench

Registered 1-to-2 demultiplexer: accepts one 32-bit word per cycle on a valid/ready input and steers it to output 0 or output 1 according to `in_sel`. It is the fan-out counterpart of the datapath's 2-to-1 select muxes, for places where one producer feeds two consumers (for example a register-file write bus split toward two banks). Each output has its own one-entry buffer, so one consumer stalling never corrupts or drops data bound for the other.

---
 rtl/stream_demux_pkg.sv | 12 +
 rtl/demux_out_slot.sv | 71 +++++++
 rtl/stream_demux_1to2.sv | 64 ++++++
 tb/tb_stream_demux_1to2.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/stream_demux_pkg.sv
// Shared types and sizes for the registered 1-to-2 stream demultiplexer.
package stream_demux_pkg;

   localparam int DEMUX_WIDTH = 32;
   localparam int COUNT_WIDTH = 16;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_t;

endpackage : stream_demux_pkg

// File: rtl/demux_out_slot.sv
// One-entry output buffer of the demux: state, data register, fill/drain logic.
// Optional handshake counter enabled by the STREAM_DEMUX_COUNT_EN macro.
module demux_out_slot
   import stream_demux_pkg::*;
#(
   parameter int WIDTH = DEMUX_WIDTH
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_fill,
   input  logic [WIDTH-1:0]       i_data,
   input  logic                   i_ready,
   output logic                   o_valid,
   output logic [WIDTH-1:0]       o_data,
   output logic                   o_canAccept,
   output logic [COUNT_WIDTH-1:0] o_count
);

   slot_state_t      r_state;
   slot_state_t      w_nextState;
   logic [WIDTH-1:0] r_data;
   logic             w_drain;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= SLOT_EMPTY;
      end else begin
         r_state <= w_nextState;
      end
   end

   // A fill wins over a drain so that fill+drain in one cycle keeps the slot full.
   always_comb begin
      w_nextState = r_state;
      w_drain     = (r_state == SLOT_FULL) && i_ready;
      if (i_fill) begin
         w_nextState = SLOT_FULL;
      end else if (w_drain) begin
         w_nextState = SLOT_EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_data <= '0;
      end else if (i_fill) begin
         r_data <= i_data;
      end
   end

   assign o_valid     = (r_state == SLOT_FULL);
   assign o_data      = r_data;
   assign o_canAccept = (r_state == SLOT_EMPTY) || i_ready;

`ifdef STREAM_DEMUX_COUNT_EN
   logic [COUNT_WIDTH-1:0] r_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
      end else if (w_drain) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;
`else
   assign o_count = '0;
`endif

endmodule : demux_out_slot

// File: rtl/stream_demux_1to2.sv
// Registered 1-to-2 valid/ready demultiplexer with an independent buffer per output.
// Define STREAM_DEMUX_COUNT_EN to enable the per-port handshake counters.
module stream_demux_1to2
   import stream_demux_pkg::*;
#(
   parameter int WIDTH = DEMUX_WIDTH
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [WIDTH-1:0]       in_data,
   input  logic                   in_sel,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [WIDTH-1:0]       out0_data,
   output logic                   out0_valid,
   input  logic                   out0_ready,
   output logic [WIDTH-1:0]       out1_data,
   output logic                   out1_valid,
   input  logic                   out1_ready,
   output logic [COUNT_WIDTH-1:0] count0,
   output logic [COUNT_WIDTH-1:0] count1
);

   logic w_canAccept0;
   logic w_canAccept1;
   logic w_accept;
   logic w_fill0;
   logic w_fill1;

   // Head-of-line blocking: only the selected slot decides whether the input moves.
   assign in_ready = in_sel ? w_canAccept1 : w_canAccept0;
   assign w_accept = in_valid && in_ready;
   assign w_fill0  = w_accept && !in_sel;
   assign w_fill1  = w_accept && in_sel;

   demux_out_slot #(
      .WIDTH(WIDTH)
   ) u_slot0 (
      .clk        (clk),
      .reset      (reset),
      .i_fill     (w_fill0),
      .i_data     (in_data),
      .i_ready    (out0_ready),
      .o_valid    (out0_valid),
      .o_data     (out0_data),
      .o_canAccept(w_canAccept0),
      .o_count    (count0)
   );

   demux_out_slot #(
      .WIDTH(WIDTH)
   ) u_slot1 (
      .clk        (clk),
      .reset      (reset),
      .i_fill     (w_fill1),
      .i_data     (in_data),
      .i_ready    (out1_ready),
      .o_valid    (out1_valid),
      .o_data     (out1_data),
      .o_canAccept(w_canAccept1),
      .o_count    (count1)
   );

endmodule : stream_demux_1to2

// File: tb/tb_stream_demux_1to2.sv
// Directed, table-driven bench for stream_demux_1to2 plus hand-written corner sequences.
// Counter expectations follow STREAM_DEMUX_COUNT_EN (zero when undefined).
module tb_stream_demux_1to2;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] in_data;
   logic        in_sel;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] out0_data;
   logic        out0_valid;
   logic        out0_ready;
   logic [31:0] out1_data;
   logic        out1_valid;
   logic        out1_ready;
   logic [15:0] count0;
   logic [15:0] count1;

   int numApplied    = 0;
   int numMiscompares = 0;

   typedef struct {
      logic        inValid;
      logic        inSel;
      logic [31:0] inData;
      logic        rdy0;
      logic        rdy1;
      logic        expReady;
      logic        expV0;
      logic [31:0] expD0;
      logic        expV1;
      logic [31:0] expD1;
      logic [15:0] expC0;
      logic [15:0] expC1;
   } vec_t;

   vec_t vecs[13];

   always #5 clk = ~clk;

   stream_demux_1to2 dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out0_data (out0_data),
      .out0_valid(out0_valid),
      .out0_ready(out0_ready),
      .out1_data (out1_data),
      .out1_valid(out1_valid),
      .out1_ready(out1_ready),
      .count0    (count0),
      .count1    (count1)
   );

   // Counters read as zero when the counting feature is compiled out.
   function automatic logic [15:0] expCount(input logic [15:0] c);
`ifdef STREAM_DEMUX_COUNT_EN
      return c;
`else
      return 16'h0000;
`endif
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      numApplied++;
      if (actual !== expected) begin
         numMiscompares++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Inputs change on the falling edge, well away from the sampling rising edge.
   task automatic applyStimulus(input logic rst, input logic v, input logic s, input logic [31:0] d,
                                input logic r0, input logic r1);
      @(negedge clk);
      reset      = rst;
      in_valid   = v;
      in_sel     = s;
      in_data    = d;
      out0_ready = r0;
      out1_ready = r1;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, " out0_valid"}, {31'b0, out0_valid}, 32'd0);
      checkOutput({tag, " out1_valid"}, {31'b0, out1_valid}, 32'd0);
      checkOutput({tag, " out0_data"}, out0_data, 32'd0);
      checkOutput({tag, " out1_data"}, out1_data, 32'd0);
      checkOutput({tag, " count0"}, {16'b0, count0}, 32'd0);
      checkOutput({tag, " count1"}, {16'b0, count1}, 32'd0);
   endtask

   initial begin
      reset      = 1'b1;
      in_valid   = 1'b0;
      in_sel     = 1'b0;
      in_data    = '0;
      out0_ready = 1'b1;
      out1_ready = 1'b1;

      // Sequence starts from reset with both slots empty.
      vecs[0]  = '{1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0,        16'd0, 16'd0};
      vecs[1]  = '{1'b1, 1'b1, 32'h12345678, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h12345678, 16'd1, 16'd0};
      vecs[2]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        16'd1, 16'd1};
      vecs[3]  = '{1'b1, 1'b0, 32'h0000000A, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000000A, 1'b0, 32'h0,        16'd1, 16'd1};
      vecs[4]  = '{1'b1, 1'b0, 32'h0000000B, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000000A, 1'b0, 32'h0,        16'd1, 16'd1};
      vecs[5]  = '{1'b1, 1'b1, 32'h0000000C, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000000A, 1'b1, 32'h0000000C, 16'd1, 16'd1};
      vecs[6]  = '{1'b1, 1'b0, 32'h0000000B, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000000A, 1'b0, 32'h0,        16'd1, 16'd2};
      vecs[7]  = '{1'b1, 1'b0, 32'h0000000B, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000000B, 1'b0, 32'h0,        16'd2, 16'd2};
      vecs[8]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        16'd3, 16'd2};
      vecs[9]  = '{1'b1, 1'b0, 32'h00000055, 1'b1, 1'b1, 1'b1, 1'b1, 32'h00000055, 1'b0, 32'h0,        16'd3, 16'd2};
      vecs[10] = '{1'b1, 1'b1, 32'h00000066, 1'b0, 1'b1, 1'b1, 1'b1, 32'h00000055, 1'b1, 32'h00000066, 16'd3, 16'd2};
      vecs[11] = '{1'b1, 1'b0, 32'h00000077, 1'b1, 1'b1, 1'b1, 1'b1, 32'h00000077, 1'b0, 32'h0,        16'd4, 16'd3};
      vecs[12] = '{1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        16'd5, 16'd3};

      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      tick();
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      checkIdle("reset");
      checkOutput("reset in_ready sel0", {31'b0, in_ready}, 32'd1);
      in_sel = 1'b1;
      #1;
      checkOutput("reset in_ready sel1", {31'b0, in_ready}, 32'd1);

      for (int i = 0; i < 13; i++) begin
         applyStimulus(1'b0, vecs[i].inValid, vecs[i].inSel, vecs[i].inData, vecs[i].rdy0, vecs[i].rdy1);
         checkOutput($sformatf("v%0d in_ready", i), {31'b0, in_ready}, {31'b0, vecs[i].expReady});
         tick();
         checkOutput($sformatf("v%0d out0_valid", i), {31'b0, out0_valid}, {31'b0, vecs[i].expV0});
         checkOutput($sformatf("v%0d out1_valid", i), {31'b0, out1_valid}, {31'b0, vecs[i].expV1});
         if (vecs[i].expV0) checkOutput($sformatf("v%0d out0_data", i), out0_data, vecs[i].expD0);
         if (vecs[i].expV1) checkOutput($sformatf("v%0d out1_data", i), out1_data, vecs[i].expD1);
         checkOutput($sformatf("v%0d count0", i), {16'b0, count0}, {16'b0, expCount(vecs[i].expC0)});
         checkOutput($sformatf("v%0d count1", i), {16'b0, count1}, {16'b0, expCount(vecs[i].expC1)});
      end

      // Back-to-back streaming to port 0 from a fresh reset.
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      tick();
      for (int i = 0; i < 100; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 32'hC0DE0000 + i, 1'b1, 1'b1);
         checkOutput($sformatf("stream%0d in_ready", i), {31'b0, in_ready}, 32'd1);
         tick();
         checkOutput($sformatf("stream%0d out0_valid", i), {31'b0, out0_valid}, 32'd1);
         checkOutput($sformatf("stream%0d out0_data", i), out0_data, 32'hC0DE0000 + i);
         checkOutput($sformatf("stream%0d out1_valid", i), {31'b0, out1_valid}, 32'd0);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      tick();
      checkOutput("stream out0_valid end", {31'b0, out0_valid}, 32'd0);
      checkOutput("stream count0", {16'b0, count0}, {16'b0, expCount(16'd100)});

      // Reset with both slots full discards them and ignores the reset-cycle handshake.
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h00000011, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h00000022, 1'b0, 1'b0);
      tick();
      checkOutput("full out0_valid", {31'b0, out0_valid}, 32'd1);
      checkOutput("full out1_valid", {31'b0, out1_valid}, 32'd1);
      checkOutput("full out0_data", out0_data, 32'h00000011);
      checkOutput("full out1_data", out1_data, 32'h00000022);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h00000033, 1'b1, 1'b1);
      tick();
      checkIdle("midreset");
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      checkOutput("midreset in_ready", {31'b0, in_ready}, 32'd1);
      tick();
      checkIdle("postreset");

`ifdef STREAM_DEMUX_COUNT_EN
      // Counter wrap: 65537 handshakes on port 1 leave count1 at 1.
      for (int i = 0; i < 65537; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b1, i, 1'b1, 1'b1);
         tick();
      end
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1);
      tick();
      checkOutput("wrap count1", {16'b0, count1}, 32'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", numApplied, numMiscompares);
      $finish;
   end

endmodule : tb_stream_demux_1to2
